image_memory_banked: RTL and testbench
======================================

Name: image_memory_banked

Overview:
Parametrised successor to the image memory model: WIDTH-bit words, DEPTH entries, two read ports and two write ports per cycle. Adds selectable read latency, defined read-during-write and write-write collision behaviour, out-of-bounds detection, and a hardware clear sequencer that runs after reset or on request. Sits between the image loader/DMA and the conv datapath.

Parameters:
WIDTH, 18, data word width in bits
DEPTH, 61440, number of words (60 x 1024)
ADDR_W, 16, address width; must satisfy 2^ADDR_W >= DEPTH
READ_LATENCY, 1, clocks from rd_en to rd_valid; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = run clear sequence after reset release; 0 = go straight to READY

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
rd_en_a  in  1  read request, port A
rd_addr_a  in  ADDR_W  read address, port A
rd_data_a  out  WIDTH  read data, port A
rd_valid_a  out  1  rd_data_a valid this cycle
rd_en_b, rd_addr_b, rd_data_b, rd_valid_b  as port A
wr_en_a  in  1  write enable, port A
wr_addr_a  in  ADDR_W  write address, port A
wr_data_a  in  WIDTH  write data, port A
wr_en_b, wr_addr_b, wr_data_b  as port A
clr_start  in  1  request a full clear (single-cycle pulse)
busy  out  1  clear sequence in progress
err_oob  out  1  sticky out-of-bounds access flag

Behaviour:
- Reset (rst_n low, async): rd_data_* = 0, rd_valid_* = 0, err_oob = 0, clear pointer = 0; FSM -> CLEAR if CLEAR_ON_RESET else READY; busy = 1 in CLEAR, 0 in READY. Array contents are not reset directly.
- FSM states: CLEAR, READY.
- CLEAR: each cycle writes fill value to ptr and ptr+1 (ptr+1 only if < DEPTH); ptr += 2. When ptr+2 >= DEPTH the last pair is written and the FSM enters READY next cycle. Clear takes ceil(DEPTH/2) cycles. busy = 1 throughout.
- In CLEAR: external wr_en_* ignored; rd_en_* ignored (no rd_valid); clr_start ignored (no restart).
- READY: clr_start = 1 -> CLEAR with ptr = 0, err_oob cleared on the same edge.
- Reset asserted mid-clear: sequence restarts from ptr = 0 after release (if CLEAR_ON_RESET).
- Reads: rd_en sampled at edge N; rd_data/rd_valid presented after edge N+READ_LATENCY-1, valid for one cycle. Fully pipelined, one read per port per cycle. rd_data holds its last value when rd_valid = 0.
- Read-during-write, same address, same cycle: write-first; read returns the newly written data.
- Write-write collision (both wr_en, same address): port A data stored, port B dropped; a same-cycle read of that address returns port A data.
- Out-of-bounds (enabled access with addr >= DEPTH): write dropped; read returns 0 with rd_valid asserted normally. Any OOB access sets err_oob, which stays set until reset or an accepted clr_start.
- Widths: addresses compared unsigned; no truncation or wrap-around of addresses.

Optional Feature:
Macro MEMORY_INIT_DEC_EN. Defined: clear fill value for address i is (i*10) truncated to WIDTH bits (deterministic test pattern). Undefined: fill value is 0. Applies to both post-reset and clr_start clears.

Test Plan:
- DEPTH=8, CLEAR_ON_RESET=1: release rst_n -> busy high exactly 4 cycles then low; reads of 0..7 return 0 (or 0,10,...,70 with MEMORY_INIT_DEC_EN).
- READY, READ_LATENCY=2: write 0x155 at addr 3, then rd_en_a addr 3 at edge N -> rd_valid_a and rd_data_a=0x155 after edge N+1 only; with READ_LATENCY=1 after edge N.
- Same cycle: wr_en_a addr 5 data 0x0AA, wr_en_b addr 5 data 0x0BB, rd_en_b addr 5 -> rd_data_b=0x0AA; later read of addr 5 returns 0x0AA.
- DEPTH=8: wr_en_a addr 9 data 0x3 and rd_en_b addr 12 -> no write, rd_data_b=0, rd_valid_b=1, err_oob=1 and stays 1; clr_start -> err_oob=0, busy=1.
- Mid-clear: assert rst_n low at 2nd clear cycle -> outputs 0 immediately; after release full 4-cycle clear runs from addr 0; wr_en/rd_en/clr_start during busy have no effect.

Source files
------------

// File: rtl/image_memory_banked_if.sv
// Bus bundle for image_memory_banked: two read ports, two write ports, clear control.
//   master: drives read/write requests and clr_start; receives read data/valid, busy, err_oob.
//   slave : the memory side of the same signals.
interface image_memory_banked_if #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned ADDR_W = 16
);
  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic              rd_valid_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              rd_valid_b;
  logic              wr_en_a;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [WIDTH-1:0]  wr_data_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [WIDTH-1:0]  wr_data_b;
  logic              clr_start;
  logic              busy;
  logic              err_oob;

  modport master (
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b,
    output clr_start,
    input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy, err_oob
  );

  modport slave (
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b,
    input  clr_start,
    output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy, err_oob
  );
endinterface

// File: rtl/image_memory_banked.sv
// Dual-read / dual-write image memory with selectable read latency (1 or 2), write-first
// read-during-write, port-A-wins write collisions, out-of-bounds detection and a hardware
// clear sequencer (two words per cycle) that runs after reset or on clr_start.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - image_memory_banked_if.slave (read/write ports, clr_start, busy, err_oob)
// Optional feature macro: MEMORY_INIT_DEC_EN -- clear writes (i*10) mod 2^WIDTH to address i
// instead of zero.
module image_memory_banked #(
  parameter int unsigned WIDTH          = 18,
  parameter int unsigned DEPTH          = 61440,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  image_memory_banked_if.slave bus
);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PtrW = ADDR_W + 1;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d, ptr1;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              busy, ready, clr_accept, oob_hit, err_q;
  logic [WIDTH-1:0]  fill0, fill1;

  logic [1:0]                   rd_en, wr_en, rd_inb, wr_inb, rd_acc, wr_acc;
  logic [1:0][ADDR_W-1:0]       rd_addr, wr_addr;
  logic [1:0][WIDTH-1:0]        wr_data, rd_val, rd_data;
  logic [1:0]                   rd_valid;
  logic [1:0]                   s1_valid_q;
  logic [1:0][WIDTH-1:0]        s1_data_q;

  assign rd_en   = {bus.rd_en_b, bus.rd_en_a};
  assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};
  assign wr_en   = {bus.wr_en_b, bus.wr_en_a};
  assign wr_addr = {bus.wr_addr_b, bus.wr_addr_a};
  assign wr_data = {bus.wr_data_b, bus.wr_data_a};

  assign ptr1 = ptr_q + PtrW'(1);

`ifdef MEMORY_INIT_DEC_EN
  assign fill0 = WIDTH'(64'(ptr_q) * 64'd10);
  assign fill1 = WIDTH'(64'(ptr1) * 64'd10);
`else
  assign fill0 = '0;
  assign fill1 = '0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? StClear : StReady;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + PtrW'(2);
        if (32'(ptr_q) + 32'd2 >= DEPTH) state_d = StReady;
      end
      StReady: begin
        if (bus.clr_start) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      default: state_d = StReady;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q == StClear);
    ready      = (state_q == StReady);
    clr_accept = ready && bus.clr_start;
  end

  // Request qualification; external accesses only count while READY.
  always_comb begin
    rd_val = '0;
    for (int p = 0; p < 2; p++) begin
      rd_inb[p] = 32'(rd_addr[p]) < DEPTH;
      wr_inb[p] = 32'(wr_addr[p]) < DEPTH;
      rd_acc[p] = ready && rd_en[p];
      wr_acc[p] = ready && wr_en[p] && wr_inb[p];
    end
    for (int p = 0; p < 2; p++) begin
      // Write-first bypass, port A has priority over port B.
      if (rd_inb[p]) begin
        if (wr_acc[0] && wr_addr[0] == rd_addr[p])      rd_val[p] = wr_data[0];
        else if (wr_acc[1] && wr_addr[1] == rd_addr[p]) rd_val[p] = wr_data[1];
        else                                            rd_val[p] = mem_q[rd_addr[p][IdxW-1:0]];
      end
    end
    oob_hit = ready && ((|(rd_en & ~rd_inb)) || (|(wr_en & ~wr_inb)));
  end

  // Storage; port A written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[ptr_q[IdxW-1:0]] <= fill0;
      if (32'(ptr1) < DEPTH) mem_q[ptr1[IdxW-1:0]] <= fill1;
    end else begin
      if (wr_acc[1]) mem_q[wr_addr[1][IdxW-1:0]] <= wr_data[1];
      if (wr_acc[0]) mem_q[wr_addr[0][IdxW-1:0]] <= wr_data[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (clr_accept) begin
      err_q <= 1'b0;
    end else if (oob_hit) begin
      err_q <= 1'b1;
    end
  end

  // First read stage; data only updates on a valid read so outputs hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) s1_data_q[p] <= rd_val[p];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]            s2_valid_q;
    logic [1:0][WIDTH-1:0] s2_data_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= '0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        for (int p = 0; p < 2; p++) begin
          if (s1_valid_q[p]) s2_data_q[p] <= s1_data_q[p];
        end
      end
    end
    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

  assign bus.rd_data_a  = rd_data[0];
  assign bus.rd_valid_a = rd_valid[0];
  assign bus.rd_data_b  = rd_data[1];
  assign bus.rd_valid_b = rd_valid[1];
  assign bus.busy       = busy;
  assign bus.err_oob    = err_q;
endmodule

// File: tb/tb_image_memory_banked.sv
// Randomised bench for image_memory_banked: one latency-1 and one latency-2 instance share
// identical stimulus and are compared each cycle against a behavioural memory model.
module tb_image_memory_banked;
  localparam int unsigned W  = 18;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  image_memory_banked_if #(.WIDTH(W), .ADDR_W(AW)) bus1 ();
  image_memory_banked_if #(.WIDTH(W), .ADDR_W(AW)) bus2 ();

  assign bus2.rd_en_a   = bus1.rd_en_a;
  assign bus2.rd_addr_a = bus1.rd_addr_a;
  assign bus2.rd_en_b   = bus1.rd_en_b;
  assign bus2.rd_addr_b = bus1.rd_addr_b;
  assign bus2.wr_en_a   = bus1.wr_en_a;
  assign bus2.wr_addr_a = bus1.wr_addr_a;
  assign bus2.wr_data_a = bus1.wr_data_a;
  assign bus2.wr_en_b   = bus1.wr_en_b;
  assign bus2.wr_addr_b = bus1.wr_addr_b;
  assign bus2.wr_data_b = bus1.wr_data_b;
  assign bus2.clr_start = bus1.clr_start;

  image_memory_banked #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .READ_LATENCY(1),
                        .CLEAR_ON_RESET(1'b1)) u_dut_l1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  image_memory_banked #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .READ_LATENCY(2),
                        .CLEAR_ON_RESET(1'b1)) u_dut_l2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  logic [W-1:0] ref_mem [D];
  bit           ref_busy;
  int           ref_ptr;
  bit           ref_err;
  bit           iss_v [2];
  logic [W-1:0] iss_d [2];
  bit           exp_v1 [2];
  bit           exp_v2 [2];
  logic [W-1:0] exp_d1 [2];
  logic [W-1:0] exp_d2 [2];

  function automatic logic [W-1:0] fill_of(input int i);
`ifdef MEMORY_INIT_DEC_EN
    return W'(i * 10);
`else
    return W'(i * 0);
`endif
  endfunction

  task automatic model_reset();
    ref_busy = 1'b1;
    ref_ptr  = 0;
    ref_err  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      iss_v[p] = 1'b0; iss_d[p] = '0;
      exp_v1[p] = 1'b0; exp_v2[p] = 1'b0;
      exp_d1[p] = '0;  exp_d2[p] = '0;
    end
  endtask

  task automatic model_edge();
    bit re [2]; bit we [2]; int ra [2]; int wa [2]; logic [W-1:0] wd [2];
    re[0] = bus1.rd_en_a; re[1] = bus1.rd_en_b;
    ra[0] = int'(bus1.rd_addr_a); ra[1] = int'(bus1.rd_addr_b);
    we[0] = bus1.wr_en_a; we[1] = bus1.wr_en_b;
    wa[0] = int'(bus1.wr_addr_a); wa[1] = int'(bus1.wr_addr_b);
    wd[0] = bus1.wr_data_a; wd[1] = bus1.wr_data_b;
    // latency-2 outputs show what was issued one edge earlier
    for (int p = 0; p < 2; p++) begin
      exp_v2[p] = iss_v[p];
      if (iss_v[p]) exp_d2[p] = iss_d[p];
      iss_v[p] = 1'b0;
    end
    if (ref_busy) begin
      ref_mem[ref_ptr] = fill_of(ref_ptr);
      if (ref_ptr + 1 < D) ref_mem[ref_ptr + 1] = fill_of(ref_ptr + 1);
      if (ref_ptr + 2 >= D) ref_busy = 1'b0;
      ref_ptr += 2;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (re[p]) begin
          iss_v[p] = 1'b1;
          if (ra[p] >= D)                           iss_d[p] = '0;
          else if (we[0] && wa[0] == ra[p])         iss_d[p] = wd[0];
          else if (we[1] && wa[1] == ra[p])         iss_d[p] = wd[1];
          else                                      iss_d[p] = ref_mem[ra[p]];
        end
      end
      if (we[1] && wa[1] < D) ref_mem[wa[1]] = wd[1];
      if (we[0] && wa[0] < D) ref_mem[wa[0]] = wd[0];
      if (bus1.clr_start) begin
        ref_err = 1'b0; ref_busy = 1'b1; ref_ptr = 0;
      end else if ((re[0] && ra[0] >= D) || (re[1] && ra[1] >= D) ||
                   (we[0] && wa[0] >= D) || (we[1] && wa[1] >= D)) begin
        ref_err = 1'b1;
      end
    end
    for (int p = 0; p < 2; p++) begin
      exp_v1[p] = iss_v[p];
      if (iss_v[p]) exp_d1[p] = iss_d[p];
    end
  endtask

  task automatic check_outputs();
    check_val("l1_busy", 32'(bus1.busy), 32'(ref_busy));
    check_val("l2_busy", 32'(bus2.busy), 32'(ref_busy));
    check_val("l1_err", 32'(bus1.err_oob), 32'(ref_err));
    check_val("l2_err", 32'(bus2.err_oob), 32'(ref_err));
    check_val("l1_valid_a", 32'(bus1.rd_valid_a), 32'(exp_v1[0]));
    check_val("l1_valid_b", 32'(bus1.rd_valid_b), 32'(exp_v1[1]));
    check_val("l1_data_a", 32'(bus1.rd_data_a), 32'(exp_d1[0]));
    check_val("l1_data_b", 32'(bus1.rd_data_b), 32'(exp_d1[1]));
    check_val("l2_valid_a", 32'(bus2.rd_valid_a), 32'(exp_v2[0]));
    check_val("l2_valid_b", 32'(bus2.rd_valid_b), 32'(exp_v2[1]));
    check_val("l2_data_a", 32'(bus2.rd_data_a), 32'(exp_d2[0]));
    check_val("l2_data_b", 32'(bus2.rd_data_b), 32'(exp_d2[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    bus1.rd_en_a = 1'b0; bus1.rd_addr_a = '0;
    bus1.rd_en_b = 1'b0; bus1.rd_addr_b = '0;
    bus1.wr_en_a = 1'b0; bus1.wr_addr_a = '0; bus1.wr_data_a = '0;
    bus1.wr_en_b = 1'b0; bus1.wr_addr_b = '0; bus1.wr_data_b = '0;
    bus1.clr_start = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(D, 15));
    return AW'($urandom_range(0, D - 1));
  endfunction

  task automatic rand_inputs(input int clr_odds);
    bus1.rd_en_a = 1'($urandom_range(0, 1)); bus1.rd_addr_a = rand_addr();
    bus1.rd_en_b = 1'($urandom_range(0, 1)); bus1.rd_addr_b = rand_addr();
    bus1.wr_en_a = 1'($urandom_range(0, 1)); bus1.wr_addr_a = rand_addr();
    bus1.wr_data_a = W'($urandom);
    bus1.wr_en_b = 1'($urandom_range(0, 1)); bus1.wr_addr_b = rand_addr();
    bus1.wr_data_b = W'($urandom);
    bus1.clr_start = ($urandom_range(0, clr_odds - 1) == 0);
  endtask

  // Asynchronous reset applied between edges; outputs must react without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < D; i++) begin
      idle();
      bus1.rd_en_a = 1'b1; bus1.rd_addr_a = AW'(i);
      bus1.rd_en_b = 1'b1; bus1.rd_addr_b = AW'(D - 1 - i);
      tick();
    end
    idle();
    repeat (2) tick();
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // Post-reset clear: busy for exactly D/2 cycles
    repeat (3) tick();
    check_val("clear_busy_c3", 32'(bus1.busy), 32'd1);
    tick();
    check_val("clear_done_c4", 32'(bus1.busy), 32'd0);
    read_all();

    // Read latency
    idle(); bus1.wr_en_a = 1'b1; bus1.wr_addr_a = 4'd3; bus1.wr_data_a = 18'h155;
    tick();
    idle(); bus1.rd_en_a = 1'b1; bus1.rd_addr_a = 4'd3;
    tick();
    check_val("lat1_valid", 32'(bus1.rd_valid_a), 32'd1);
    check_val("lat1_data", 32'(bus1.rd_data_a), 32'h155);
    check_val("lat2_early", 32'(bus2.rd_valid_a), 32'd0);
    idle();
    tick();
    check_val("lat2_valid", 32'(bus2.rd_valid_a), 32'd1);
    check_val("lat2_data", 32'(bus2.rd_data_a), 32'h155);
    check_val("lat1_hold", 32'(bus1.rd_data_a), 32'h155);

    // Write-write collision with same-cycle read
    idle();
    bus1.wr_en_a = 1'b1; bus1.wr_addr_a = 4'd5; bus1.wr_data_a = 18'h0AA;
    bus1.wr_en_b = 1'b1; bus1.wr_addr_b = 4'd5; bus1.wr_data_b = 18'h0BB;
    bus1.rd_en_b = 1'b1; bus1.rd_addr_b = 4'd5;
    tick();
    check_val("coll_rd_b", 32'(bus1.rd_data_b), 32'h0AA);
    idle(); bus1.rd_en_a = 1'b1; bus1.rd_addr_a = 4'd5;
    tick();
    check_val("coll_later", 32'(bus1.rd_data_a), 32'h0AA);
    idle();
    repeat (2) tick();

    // Out of bounds
    idle();
    bus1.wr_en_a = 1'b1; bus1.wr_addr_a = 4'd9; bus1.wr_data_a = 18'h3;
    bus1.rd_en_b = 1'b1; bus1.rd_addr_b = 4'd12;
    tick();
    check_val("oob_valid", 32'(bus1.rd_valid_b), 32'd1);
    check_val("oob_data", 32'(bus1.rd_data_b), 32'd0);
    check_val("oob_err", 32'(bus1.err_oob), 32'd1);
    idle();
    repeat (3) tick();
    read_all();
    check_val("oob_sticky", 32'(bus1.err_oob), 32'd1);
    idle(); bus1.clr_start = 1'b1;
    tick();
    check_val("clr_busy", 32'(bus1.busy), 32'd1);
    check_val("clr_err", 32'(bus1.err_oob), 32'd0);
    // Activity during clear is ignored
    for (int i = 0; i < 4; i++) begin
      rand_inputs(2);
      tick();
    end
    idle();
    read_all();

    // Reset in the middle of a clear
    idle(); bus1.clr_start = 1'b1;
    tick();
    idle();
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_inputs(2);
      tick();
    end
    check_val("rst_clear_done", 32'(bus1.busy), 32'd0);
    idle();
    read_all();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rand_inputs(50);
      tick();
    end
    idle();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
